// File: rtl/reg_cmd_parser_pkg.sv
// Shared definitions for the register command parser.
//   state_t     : FSM state encoding
//   CMD_*       : command bytes accepted in IDLE
//   RESP_*      : fixed response bytes returned to the host
package reg_cmd_parser_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ADDR = 3'd1,
        GET_DATA = 3'd2,
        REQ      = 3'd3,
        SETTLE   = 3'd4,
        RELEASE  = 3'd5,
        RESP     = 3'd6
    } state_t;

    localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
    localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] RESP_OK   = 8'h4B;  // 'K'
    localparam logic [7:0] RESP_ERR  = 8'h45;  // 'E'

endpackage

// File: rtl/reg_cmd_parser_timeout.sv
// cmd_timeout: loadable down-counter with an expiry strobe.
//   clk, nRst : clock, async active-low reset
//   load      : restart the count at CYCLES
//   en        : count while high
//   expired   : high for the cycle in which CYCLES enabled cycles have
//               passed since the last load
module cmd_timeout #(
    parameter int CYCLES = 20
) (
    input  logic clk,
    input  logic nRst,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int             W    = $clog2(CYCLES + 1);
    localparam logic [W-1:0]   INIT = W'(CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)                  cnt <= '0;
        else if (load)              cnt <= INIT;
        else if (en && cnt != '0)   cnt <= cnt - W'(1);
    end

    // A load in the same cycle wins: a fresh byte always restarts the wait.
    assign expired = en && !load && (cnt == '0);

endmodule

// File: rtl/reg_cmd_parser.sv
// reg_cmd_parser: turns UART bytes 'R' addr / 'W' addr data into a
// request/acknowledge handshake with a register block and sends back one
// response byte (read data, 'K' for write, 'E' for bad address).
//   clk, nRst            : 50 MHz clock, async active-low reset
//   rx_data, rx_valid    : incoming byte and strobe
//   reg_data             : address, then write data, to the register block
//   reg_read, reg_write  : request levels, held until reg_valid
//   reg_rdata, reg_valid : read data and acknowledge level
//   tx_data, tx_start    : response byte and launch strobe
//   tx_busy              : transmitter busy, delays tx_start
//   busy                 : high whenever not in IDLE
// Optional: define CMD_TIMEOUT_EN to abandon a command after
// TIMEOUT_CYCLES cycles without a byte in GET_ADDR/GET_DATA.
module reg_cmd_parser
    import reg_cmd_parser_pkg::*;
#(
    parameter int NUM_REGS       = 15,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] reg_data,
    output logic       reg_read,
    output logic       reg_write,
    input  logic [7:0] reg_rdata,
    input  logic       reg_valid,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic       busy
);

    localparam logic [7:0] NREG = 8'(NUM_REGS);

    state_t     state, state_nxt;
    logic       is_wr;
    logic [7:0] addr_q, data_q, rdata_q;
    logic       is_cmd, bad_addr, tmo_expired;

    assign is_cmd   = (rx_data == CMD_READ) || (rx_data == CMD_WRITE);
    assign bad_addr = (rx_data >= NREG);

`ifdef CMD_TIMEOUT_EN
    logic tmo_load, tmo_en;
    assign tmo_load = rx_valid && (state == IDLE || state == GET_ADDR || state == GET_DATA);
    assign tmo_en   = (state == GET_ADDR) || (state == GET_DATA);

    cmd_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .nRst    (nRst),
        .load    (tmo_load),
        .en      (tmo_en),
        .expired (tmo_expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign tmo_expired    = 1'b0;
`endif

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        reg_read  = 1'b0;
        reg_write = 1'b0;
        tx_start  = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:     if (rx_valid && is_cmd) state_nxt = GET_ADDR;
            GET_ADDR: begin
                if (rx_valid) begin
                    if (bad_addr)   state_nxt = RESP;
                    else if (is_wr) state_nxt = GET_DATA;
                    else            state_nxt = REQ;
                end else if (tmo_expired) begin
                    state_nxt = IDLE;
                end
            end
            GET_DATA: begin
                if (rx_valid)         state_nxt = REQ;
                else if (tmo_expired) state_nxt = IDLE;
            end
            REQ: begin
                reg_read  = !is_wr;
                reg_write = is_wr;
                if (reg_valid) state_nxt = is_wr ? SETTLE : RELEASE;
            end
            SETTLE: begin
                reg_write = 1'b1;
                state_nxt = RELEASE;
            end
            RELEASE:  if (!reg_valid) state_nxt = RESP;
            RESP: begin
                if (!tx_busy) begin
                    tx_start  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default:  state_nxt = IDLE;
        endcase
    end

    // Datapath: reg_data and tx_data are registers so they are stable for
    // the whole state that presents them, and hold between transactions.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            is_wr    <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            rdata_q  <= '0;
            reg_data <= '0;
            tx_data  <= '0;
        end else begin
            case (state)
                IDLE: if (rx_valid && is_cmd) is_wr <= (rx_data == CMD_WRITE);
                GET_ADDR: begin
                    if (rx_valid) begin
                        addr_q <= rx_data;
                        if (bad_addr)   tx_data  <= RESP_ERR;
                        else if (!is_wr) reg_data <= rx_data;
                    end
                end
                GET_DATA: begin
                    if (rx_valid) begin
                        data_q   <= rx_data;
                        reg_data <= addr_q;
                    end
                end
                REQ: begin
                    if (reg_valid) begin
                        if (is_wr) reg_data <= data_q;
                        else       rdata_q  <= reg_rdata;
                    end
                end
                RELEASE: if (!reg_valid) tx_data <= is_wr ? RESP_OK : rdata_q;
                default: ;
            endcase
        end
    end

endmodule
